// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: issues data-memory requests for loads and stores,
// waits for ack with a bounded timeout, and produces register-file writes.
module mem_wb_stage #(
    parameter int ARQ              = 16,
    parameter int MEMORY_ADDR_SIZE = 13,
    parameter int TIMEOUT          = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_in,
    input  logic                        wb_enable_in,
    input  logic                        rd_mem_in,
    input  logic                        wr_mem_in,
    input  logic                        mux_exe_in,
    input  logic [ARQ-1:0]              alu_result_in,
    input  logic [ARQ-1:0]              src3_in,
    output logic                        stall_out,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [MEMORY_ADDR_SIZE-1:0] mem_addr,
    output logic [ARQ-1:0]              mem_wdata,
    input  logic                        mem_ack,
    input  logic [ARQ-1:0]              mem_rdata,
    output logic                        wr_reg_en,
    output logic [ARQ-1:0]              wb_result,
    output logic                        mem_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            wb_en_q;
    logic            mux_q;
    logic [ARQ-1:0]  alu_q;

    // EXE is held whenever a memory access is outstanding
    assign stall_out = (state == ACCESS);

    // Accept, memory handshake, timeout and writeback sequencing
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wr_reg_en <= 1'b0;
            wb_result <= '0;
            mem_err   <= 1'b0;
            wb_en_q   <= 1'b0;
            mux_q     <= 1'b0;
            alu_q     <= '0;
        end else begin
            wr_reg_en <= 1'b0;
            mem_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (valid_in) begin
                        if (rd_mem_in || wr_mem_in) begin
                            state     <= ACCESS;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= wr_mem_in;
                            mem_addr  <= alu_result_in[MEMORY_ADDR_SIZE-1:0];
                            mem_wdata <= src3_in;
                            wb_en_q   <= wb_enable_in;
                            mux_q     <= mux_exe_in;
                            alu_q     <= alu_result_in;
                        end else begin
                            wr_reg_en <= wb_enable_in;
                            if (wb_enable_in) begin
                                wb_result <= alu_result_in;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        wr_reg_en <= wb_en_q & ~mem_we;
                        if (wb_en_q && !mem_we) begin
                            wb_result <= mux_q ? mem_rdata : alu_q;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
